// File: rtl/stage_ex.sv
// ============================================================================
// stage_ex : MIPS execute stage with HI/LO, iterative 32-cycle multiplier, EX/MEM register
// Rev 1.0
// ============================================================================
`default_nettype none

module stage_ex (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop,
    input  logic [2:0]  alusel,
    input  logic [31:0] opv1,
    input  logic [31:0] opv2,
    input  logic        we,
    input  logic [4:0]  waddr,
    output logic        ex_we,
    output logic [4:0]  ex_waddr,
    output logic [31:0] ex_wdata,
    output logic        mem_we,
    output logic [4:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        stall_req
);
    localparam logic [2:0] C_RES_NOP   = 3'b000;
    localparam logic [2:0] C_RES_LOGIC = 3'b001;
    localparam logic [2:0] C_RES_SHIFT = 3'b010;
    localparam logic [2:0] C_RES_MOVE  = 3'b011;
    localparam logic [2:0] C_RES_ARITH = 3'b100;
    localparam logic [2:0] C_RES_MUL   = 3'b101;

    localparam logic [7:0] C_AND   = 8'b00100100;
    localparam logic [7:0] C_OR    = 8'b00100101;
    localparam logic [7:0] C_XOR   = 8'b00100110;
    localparam logic [7:0] C_NOR   = 8'b00100111;
    localparam logic [7:0] C_SLL   = 8'b01111100;
    localparam logic [7:0] C_SRL   = 8'b00000010;
    localparam logic [7:0] C_SRA   = 8'b00000011;
    localparam logic [7:0] C_MOVZ  = 8'b00001010;
    localparam logic [7:0] C_MOVN  = 8'b00001011;
    localparam logic [7:0] C_MFHI  = 8'b00010000;
    localparam logic [7:0] C_MTHI  = 8'b00010001;
    localparam logic [7:0] C_MFLO  = 8'b00010010;
    localparam logic [7:0] C_MTLO  = 8'b00010011;
    localparam logic [7:0] C_SLT   = 8'b00101010;
    localparam logic [7:0] C_SLTU  = 8'b00101011;
    localparam logic [7:0] C_ADD   = 8'b00100000;
    localparam logic [7:0] C_ADDU  = 8'b00100001;
    localparam logic [7:0] C_SUB   = 8'b00100010;
    localparam logic [7:0] C_SUBU  = 8'b00100011;
    localparam logic [7:0] C_ADDI  = 8'b01010101;
    localparam logic [7:0] C_ADDIU = 8'b01010110;
    localparam logic [7:0] C_CLZ   = 8'b10110000;
    localparam logic [7:0] C_CLO   = 8'b10110001;
    localparam logic [7:0] C_MULT  = 8'b00011000;
    localparam logic [7:0] C_MULTU = 8'b00011001;
    localparam logic [7:0] C_MUL   = 8'b10101001;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] hi_q, lo_q, mplier_q;
    logic [63:0] mcand_q, acc_q;
    logic        neg_q;

    logic        w_is_mul, w_mul_signed, w_ov, w_we_ok;
    logic [31:0] w_abs1, w_abs2, w_sum, w_diff, w_res;
    logic [63:0] w_product;

    function automatic logic [31:0] lead_count(input logic [31:0] v, input logic b);
        logic [5:0] n;
        logic       stop;
        n    = '0;
        stop = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!stop) begin
                if (v[i] == b) n = n + 6'd1;
                else           stop = 1'b1;
            end
        end
        return {26'b0, n};
    endfunction

    assign w_is_mul     = (aluop == C_MULT) || (aluop == C_MULTU) || (aluop == C_MUL);
    assign w_mul_signed = (aluop != C_MULTU);
    assign w_abs1       = (w_mul_signed && opv1[31]) ? -opv1 : opv1;
    assign w_abs2       = (w_mul_signed && opv2[31]) ? -opv2 : opv2;
    assign w_sum        = opv1 + opv2;
    assign w_diff       = opv1 - opv2;
    assign w_product    = neg_q ? -acc_q : acc_q;

    // The presentation cycle of a multiply stalls too, giving 33 stall cycles in total.
    assign stall_req = !rst && ((state_q == S_IDLE && w_is_mul) || state_q == S_RUN);

    always_comb begin
        w_res   = '0;
        w_ov    = 1'b0;
        w_we_ok = 1'b1;
        case (alusel)
            C_RES_LOGIC: begin
                case (aluop)
                    C_OR:    w_res = opv1 | opv2;
                    C_AND:   w_res = opv1 & opv2;
                    C_XOR:   w_res = opv1 ^ opv2;
                    C_NOR:   w_res = ~(opv1 | opv2);
                    default: w_res = '0;
                endcase
            end
            C_RES_SHIFT: begin
                case (aluop)
                    C_SLL:   w_res = opv2 << opv1[4:0];
                    C_SRL:   w_res = opv2 >> opv1[4:0];
                    C_SRA:   w_res = $unsigned($signed(opv2) >>> opv1[4:0]);
                    default: w_res = '0;
                endcase
            end
            C_RES_MOVE: begin
                case (aluop)
                    C_MFHI:         w_res = hi_q;
                    C_MFLO:         w_res = lo_q;
                    C_MOVN, C_MOVZ: w_res = opv1;
                    C_MTHI, C_MTLO: w_we_ok = 1'b0;
                    default:        w_res = '0;
                endcase
            end
            C_RES_ARITH: begin
                case (aluop)
                    C_ADD, C_ADDI: begin
                        w_res = w_sum;
                        w_ov  = (opv1[31] == opv2[31]) && (w_sum[31] != opv1[31]);
                    end
                    C_ADDU, C_ADDIU: w_res = w_sum;
                    C_SUB: begin
                        w_res = w_diff;
                        w_ov  = (opv1[31] != opv2[31]) && (w_diff[31] != opv1[31]);
                    end
                    C_SUBU:  w_res = w_diff;
                    C_SLT:   w_res = {31'b0, $signed(opv1) < $signed(opv2)};
                    C_SLTU:  w_res = {31'b0, opv1 < opv2};
                    C_CLZ:   w_res = lead_count(opv1, 1'b0);
                    C_CLO:   w_res = lead_count(opv1, 1'b1);
                    default: w_res = '0;
                endcase
            end
            C_RES_MUL: w_res = w_product[31:0];
            default:   w_we_ok = 1'b0;
        endcase
    end

    assign ex_we    = !rst && we && w_we_ok && !w_ov && !stall_req;
    assign ex_waddr = waddr;
    assign ex_wdata = rst ? 32'b0 : w_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_is_mul) begin
                        state_q  <= S_RUN;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mcand_q  <= {32'b0, w_abs1};
                        mplier_q <= w_abs2;
                        neg_q    <= w_mul_signed && (opv1[31] ^ opv2[31]);
                    end else if (alusel == C_RES_MOVE) begin
                        if (aluop == C_MTHI) hi_q <= opv1;
                        if (aluop == C_MTLO) lo_q <= opv1;
                    end
                end
                S_RUN: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= S_DONE;
                end
                S_DONE: begin
                    if (aluop == C_MULT || aluop == C_MULTU) begin
                        hi_q <= w_product[63:32];
                        lo_q <= w_product[31:0];
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || stall_req) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we    <= ex_we;
            mem_waddr <= ex_waddr;
            mem_wdata <= ex_wdata;
        end
    end
endmodule

`default_nettype wire
